board_state_ctrl: RTL

- Owns the 6x7 Connect-4 board and feeds the VGA screen drawer through its `tiles` output.
- Accepts column drop requests from the player input logic and applies gravity.
- Alternates turns between the two players.
- After each placement, runs a sequential four-direction win check and flags win or draw.

---
 rtl/connect4_pkg.sv | 44 ++++
 rtl/connect4_run_counter.sv | 66 ++++++
 rtl/board_state_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/connect4_pkg.sv
// Shared types and board geometry for the Connect-4 board controller.
package connect4_pkg;

    localparam int unsigned ROWS = 6;
    localparam int unsigned COLS = 7;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        P1    = 2'b01,
        P2    = 2'b10
    } tile_t;

    typedef tile_t [0:ROWS-1][0:COLS-1] board_t;

    typedef enum logic [2:0] {
        StIdle,
        StPlace,
        StCheck,
        StWin,
        StDraw
    } state_t;

    typedef enum logic [1:0] {
        HORIZ,
        VERT,
        DIAG_DR,
        DIAG_UR
    } dir_t;

    function automatic board_t empty_board();
        board_t b;
        for (int r = 0; r < int'(ROWS); r++) begin
            for (int c = 0; c < int'(COLS); c++) begin
                b[r][c] = EMPTY;
            end
        end
        return b;
    endfunction

    function automatic tile_t other_player(input tile_t p);
        return (p == P1) ? P2 : P1;
    endfunction

endpackage

// File: rtl/connect4_run_counter.sv
// Combinational run-length measure through one cell along one direction,
// saturated at WIN_LEN.
module connect4_run_counter
    import connect4_pkg::*;
#(
    parameter int unsigned WIN_LEN = 4
) (
    input  board_t      board,
    input  logic [2:0]  row,
    input  logic [2:0]  col,
    input  tile_t       colour,
    input  dir_t        dir,
    output logic [2:0]  run
);

    int dr;
    int dc;
    int pos_cnt;
    int neg_cnt;
    int total;

    always_comb begin
        dr = 0;
        dc = 1;
        unique case (dir)
            HORIZ:   begin dr = 0;  dc = 1; end
            VERT:    begin dr = 1;  dc = 0; end
            DIAG_DR: begin dr = 1;  dc = 1; end
            DIAG_UR: begin dr = -1; dc = 1; end
        endcase
    end

    // Walk outward in each sense; a run stops at the first miss or board edge.
    always_comb begin
        int  r;
        int  c;
        bit  live;
        pos_cnt = 0;
        neg_cnt = 0;
        live    = 1'b1;
        for (int k = 1; k < int'(WIN_LEN); k++) begin
            r = int'(row) + dr * k;
            c = int'(col) + dc * k;
            if (live && r >= 0 && r < int'(ROWS) && c >= 0 && c < int'(COLS) &&
                board[r[2:0]][c[2:0]] == colour) begin
                pos_cnt = pos_cnt + 1;
            end else begin
                live = 1'b0;
            end
        end
        live = 1'b1;
        for (int k = 1; k < int'(WIN_LEN); k++) begin
            r = int'(row) - dr * k;
            c = int'(col) - dc * k;
            if (live && r >= 0 && r < int'(ROWS) && c >= 0 && c < int'(COLS) &&
                board[r[2:0]][c[2:0]] == colour) begin
                neg_cnt = neg_cnt + 1;
            end else begin
                live = 1'b0;
            end
        end
        total = 1 + pos_cnt + neg_cnt;
        run   = (total >= int'(WIN_LEN)) ? 3'(WIN_LEN) : 3'(total);
    end

endmodule

// File: rtl/board_state_ctrl.sv
// Connect-4 board owner: gravity drops, turn order, sequential win/draw check.
// Optional TURN_TIMEOUT_EN forfeits the turn after TIMEOUT_CYCLES idle cycles.
module board_state_ctrl
    import connect4_pkg::*;
#(
    parameter int unsigned WIN_LEN        = 4,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd250_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        new_game,
    input  logic        drop_valid,
    input  logic [2:0]  drop_col,
    output logic        drop_ready,
    output logic        drop_reject,
    output board_t      tiles,
    output logic [1:0]  current_player,
    output logic        game_over,
    output logic [1:0]  winner,
    output logic [5:0]  move_count
);

    state_t               state_q, state_d;
    board_t               tiles_q, tiles_d;
    logic [COLS-1:0][2:0] height_q, height_d;
    logic [5:0]           move_count_q, move_count_d;
    tile_t                player_q, player_d;
    logic                 reject_q, reject_d;
    logic [2:0]           col_q, col_d;
    logic [2:0]           row_q, row_d;
    logic [1:0]           step_q, step_d;

    logic [2:0] run;
    logic [2:0] place_row;
    logic       accept;
    logic       col_bad;
    logic       win_hit;
    logic       board_full;
    logic       timeout;

    assign accept     = (state_q == StIdle) && drop_valid && !new_game;
    assign col_bad    = (drop_col >= 3'(COLS)) || (height_q[drop_col] == 3'(ROWS));
    assign place_row  = 3'(ROWS - 1) - height_q[col_q];
    assign win_hit    = (run >= 3'(WIN_LEN));
    assign board_full = (move_count_q == 6'(ROWS * COLS));

    connect4_run_counter #(
        .WIN_LEN (WIN_LEN)
    ) u_run_counter (
        .board  (tiles_q),
        .row    (row_q),
        .col    (col_q),
        .colour (player_q),
        .dir    (dir_t'(step_q)),
        .run    (run)
    );

`ifdef TURN_TIMEOUT_EN
    logic [31:0] idle_cnt_q, idle_cnt_d;

    // Any accepted drop (placed or refused) restarts the idle window.
    always_comb begin
        idle_cnt_d = '0;
        timeout    = 1'b0;
        if (state_q == StIdle && !new_game && !accept) begin
            if (idle_cnt_q == TIMEOUT_CYCLES - 32'd1) begin
                timeout = 1'b1;
            end else begin
                idle_cnt_d = idle_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign timeout        = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (new_game) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:  if (accept && !col_bad) state_d = StPlace;
                StPlace: state_d = StCheck;
                StCheck: begin
                    if (win_hit) begin
                        state_d = StWin;
                    end else if (step_q == 2'd3) begin
                        state_d = board_full ? StDraw : StIdle;
                    end
                end
                StWin:   state_d = StWin;
                StDraw:  state_d = StDraw;
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        drop_ready = (state_q == StIdle);
        game_over  = (state_q == StWin) || (state_q == StDraw);
        winner     = (state_q == StWin) ? player_q : EMPTY;
    end

    always_comb begin
        tiles_d      = tiles_q;
        height_d     = height_q;
        move_count_d = move_count_q;
        player_d     = player_q;
        reject_d     = 1'b0;
        col_d        = col_q;
        row_d        = row_q;
        step_d       = step_q;
        if (new_game) begin
            tiles_d      = empty_board();
            height_d     = '0;
            move_count_d = '0;
            player_d     = P1;
            step_d       = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        reject_d = col_bad;
                        col_d    = drop_col;
                    end else if (timeout) begin
                        player_d = other_player(player_q);
                    end
                end
                StPlace: begin
                    tiles_d[place_row][col_q] = player_q;
                    height_d[col_q]           = height_q[col_q] + 3'd1;
                    move_count_d              = move_count_q + 6'd1;
                    row_d                     = place_row;
                    step_d                    = '0;
                end
                StCheck: begin
                    step_d = step_q + 2'd1;
                    if (!win_hit && step_q == 2'd3 && !board_full) begin
                        player_d = other_player(player_q);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tiles_q      <= empty_board();
            height_q     <= '0;
            move_count_q <= '0;
            player_q     <= P1;
            reject_q     <= 1'b0;
            col_q        <= '0;
            row_q        <= '0;
            step_q       <= '0;
        end else begin
            tiles_q      <= tiles_d;
            height_q     <= height_d;
            move_count_q <= move_count_d;
            player_q     <= player_d;
            reject_q     <= reject_d;
            col_q        <= col_d;
            row_q        <= row_d;
            step_q       <= step_d;
        end
    end

    assign tiles          = tiles_q;
    assign current_player = player_q;
    assign drop_reject    = reject_q;
    assign move_count     = move_count_q;

endmodule
